// File: rtl/sn76489_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sn76489_pkg : shared amplitude table and mix limits for PSG voices |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
package sn76489_pkg;

  localparam int AMP_W   = 16;
  localparam int MIX_MAX = 32767;
  localparam int MIX_MIN = -32767;

  // 2 dB per step, truncated; index 15 is silence
  localparam logic [AMP_W-1:0] ATT_TABLE [16] = '{
    16'd32767, 16'd26027, 16'd20674, 16'd16422,
    16'd13044, 16'd10361, 16'd8230,  16'd6537,
    16'd5193,  16'd4125,  16'd3276,  16'd2602,
    16'd2067,  16'd1642,  16'd1304,  16'd0
  };

  function automatic logic [AMP_W-1:0] att_to_amp(input logic [3:0] att);
    return ATT_TABLE[att];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sn76489_tone_channel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sn76489_tone_channel : one square-wave voice with restart & DC mode |
// | Revision             : 1.0                                          |
// +--------------------------------------------------------------------+
module sn76489_tone_channel
  import sn76489_pkg::*;
#(
  parameter int N_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic [N_W-1:0]   i_n,
  input  logic [3:0]       i_att,
  input  logic             i_phase_rst,
  output logic [AMP_W-1:0] o_out
);

  logic [N_W-1:0]   r_cnt;
  logic             r_pol;
  logic [AMP_W-1:0] r_out;
  logic [AMP_W-1:0] w_amp;
  logic [AMP_W-1:0] w_neg;

  assign w_amp = att_to_amp(i_att);
  assign w_neg = '0 - w_amp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_pol <= 1'b0;
      r_out <= '0;
    end else begin
      r_out <= r_pol ? w_amp : w_neg;
      // restart outranks the tick so a sync pulse never lands half-toggled
      if (i_phase_rst) begin
        r_cnt <= i_n;
        r_pol <= 1'b1;
      end else if (i_enable) begin
        if (i_n == '0) begin
          r_cnt <= '0;
          r_pol <= 1'b1;
        end else if (r_cnt <= N_W'(1)) begin
          r_cnt <= i_n;
          r_pol <= ~r_pol;
        end else begin
          r_cnt <= r_cnt - N_W'(1);
        end
      end
    end
  end

  assign o_out = r_out;

endmodule
`default_nettype wire

// File: rtl/sn76489_tone_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sn76489_tone_bank : NUM_CH tone voices plus saturated signed mix    |
// | Revision          : 1.0                                             |
// +--------------------------------------------------------------------+
module sn76489_tone_bank
  import sn76489_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int N_W    = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CH*N_W-1:0]   ch_n,
  input  logic [NUM_CH*4-1:0]     ch_att,
  input  logic [NUM_CH-1:0]       phase_rst,
  output logic [NUM_CH*AMP_W-1:0] ch_out,
  output logic [AMP_W-1:0]        mix_out
);

  localparam int c_SUM_W = AMP_W + $clog2(NUM_CH);
  localparam logic signed [c_SUM_W-1:0] c_SUM_MAX = c_SUM_W'(MIX_MAX);
  localparam logic signed [c_SUM_W-1:0] c_SUM_MIN = c_SUM_W'(MIX_MIN);

  logic signed [c_SUM_W-1:0] w_sum;
  logic signed [AMP_W-1:0]   w_mix_nxt;
  logic signed [AMP_W-1:0]   r_mix;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    sn76489_tone_channel #(
      .N_W (N_W)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .i_enable    (enable),
      .i_n         (ch_n[k*N_W +: N_W]),
      .i_att       (ch_att[k*4 +: 4]),
      .i_phase_rst (phase_rst[k]),
      .o_out       (ch_out[k*AMP_W +: AMP_W])
    );
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_sum = w_sum + c_SUM_W'($signed(ch_out[k*AMP_W +: AMP_W]));
    end
  end

  // symmetric clamp keeps -32768 out of the DAC path
  always_comb begin
    w_mix_nxt = w_sum[AMP_W-1:0];
    if (w_sum > c_SUM_MAX) begin
      w_mix_nxt = AMP_W'(MIX_MAX);
    end else if (w_sum < c_SUM_MIN) begin
      w_mix_nxt = AMP_W'(MIX_MIN);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mix <= '0;
    end else begin
      r_mix <= w_mix_nxt;
    end
  end

  assign mix_out = r_mix;

endmodule
`default_nettype wire

// File: tb/tb_sn76489_tone_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sn76489_tone_bank : model-checked bench for the tone bank        |
// | Revision             : 1.0                                          |
// +--------------------------------------------------------------------+
module tb_sn76489_tone_bank;

  localparam int NCH = 4;
  localparam int NW  = 10;

  logic              clk       = 1'b0;
  logic              reset     = 1'b1;
  logic              enable    = 1'b0;
  logic [NCH*NW-1:0] ch_n      = '0;
  logic [NCH*4-1:0]  ch_att    = {NCH{4'hF}};
  logic [NCH-1:0]    phase_rst = '0;
  logic [NCH*16-1:0] ch_out;
  logic [15:0]       mix_out;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int kk     = 0;

  int amp_tbl [16] = '{32767, 26027, 20674, 16422, 13044, 10361, 8230, 6537,
                       5193, 4125, 3276, 2602, 2067, 1642, 1304, 0};

  // model: current half-period length latched at reload, ticks spent in it
  int m_len  [NCH];
  int m_elap [NCH];
  bit m_p    [NCH];
  int exp_ch [NCH];
  int exp_mix;

  sn76489_tone_bank #(
    .NUM_CH (NCH),
    .N_W    (NW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .ch_n      (ch_n),
    .ch_att    (ch_att),
    .phase_rst (phase_rst),
    .ch_out    (ch_out),
    .mix_out   (mix_out)
  );

  always #5 clk = ~clk;

  function automatic int nval(int k);
    return int'(ch_n[k*NW +: NW]);
  endfunction

  function automatic int attv(int k);
    return int'(ch_att[k*4 +: 4]);
  endfunction

  function automatic int dut_ch(int k);
    return int'($signed(ch_out[k*16 +: 16]));
  endfunction

  function automatic int dut_mix();
    return int'($signed(mix_out));
  endfunction

  function automatic int clamp(int s);
    if (s > 32767) return 32767;
    if (s < -32767) return -32767;
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_ch(input int k, input int n, input int a);
    ch_n[k*NW +: NW] = NW'(n);
    ch_att[k*4 +: 4] = 4'(a);
  endtask

  task automatic step_to(input int t);
    while (kk < t) begin
      @(negedge clk);
      kk++;
    end
  endtask

  // leaves us on the negedge just before a tick edge; kk counts from there
  task automatic sync_tick();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (enable) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL sync_tick: got no enable, expected one within 40 clk");
    end
    kk = 0;
  endtask

  initial begin
    int div;
    div = 0;
    forever begin
      @(posedge clk);
      #2;
      div    = (div + 1) % 16;
      enable = (div == 0);
    end
  end

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        for (int k = 0; k < NCH; k++) begin
          m_len[k]  = 0;
          m_elap[k] = 0;
          m_p[k]    = 1'b0;
          exp_ch[k] = 0;
        end
        exp_mix = 0;
      end else begin
        int s;
        int nxt [NCH];
        s = 0;
        for (int k = 0; k < NCH; k++) begin
          s += exp_ch[k];
          nxt[k] = m_p[k] ? amp_tbl[attv(k)] : -amp_tbl[attv(k)];
        end
        for (int k = 0; k < NCH; k++) begin
          if (phase_rst[k]) begin
            m_p[k]    = 1'b1;
            m_len[k]  = nval(k);
            m_elap[k] = 0;
          end else if (enable) begin
            if (nval(k) == 0) begin
              m_p[k]    = 1'b1;
              m_len[k]  = 0;
              m_elap[k] = 0;
            end else begin
              m_elap[k]++;
              if (m_elap[k] >= m_len[k]) begin
                m_p[k]    = ~m_p[k];
                m_len[k]  = nval(k);
                m_elap[k] = 0;
              end
            end
          end
        end
        exp_mix = clamp(s);
        for (int k = 0; k < NCH; k++) exp_ch[k] = nxt[k];
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < NCH; k++) begin
          checks++;
          if (dut_ch(k) !== exp_ch[k]) begin
            errors++;
            $display("FAIL model_ch%0d: got %0d, expected %0d at %0t",
                     k, dut_ch(k), exp_ch[k], $time);
          end
        end
        checks++;
        if (dut_mix() !== exp_mix) begin
          errors++;
          $display("FAIL model_mix: got %0d, expected %0d at %0t",
                   dut_mix(), exp_mix, $time);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 reset = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ch0", dut_ch(0), 0);
    chk("reset_mix", dut_mix(), 0);
    reset = 1'b1;

    // N=1, att=1: 16-clk half periods, mix trails by one clock
    set_ch(0, 1, 1);
    sync_tick();
    step_to(1);  phase_rst[0] = 1'b1;
    step_to(2);  phase_rst[0] = 1'b0;
    step_to(10); chk("n1_pos", dut_ch(0), 26027);
    step_to(17); chk("n1_pos_last", dut_ch(0), 26027);
    step_to(18); chk("n1_neg_first", dut_ch(0), -26027);
    step_to(26); chk("n1_neg", dut_ch(0), -26027);
                 chk("n1_mix_neg", dut_mix(), -26027);
    step_to(34); chk("n1_pos_again", dut_ch(0), 26027);
                 chk("n1_mix_lag", dut_mix(), -26027);

    // N=4 then N=2 mid-period: the running half keeps its 4 ticks
    set_ch(0, 4, 8);
    sync_tick();
    step_to(1);   phase_rst[0] = 1'b1;
    step_to(2);   phase_rst[0] = 1'b0;
    step_to(40);  chk("n4_pos", dut_ch(0), 5193);
    step_to(65);  chk("n4_pos_last", dut_ch(0), 5193);
    step_to(66);  chk("n4_neg_first", dut_ch(0), -5193);
    step_to(80);  set_ch(0, 2, 8);
    step_to(100); chk("n4_neg_mid", dut_ch(0), -5193);
    step_to(129); chk("n4_neg_last", dut_ch(0), -5193);
    step_to(130); chk("n2_pos_first", dut_ch(0), 5193);
                  chk("n2_mix_lag", dut_mix(), -5193);
    step_to(161); chk("n2_pos_last", dut_ch(0), 5193);
    step_to(162); chk("n2_neg_first", dut_ch(0), -5193);

    // N=0: DC at full scale
    set_ch(0, 0, 0);
    sync_tick();
    for (int j = 0; j < 10; j++) begin
      step_to(8 + 16 * j);
      chk("dc_mode", dut_ch(0), 32767);
    end

    // restart coinciding with a tick reloads instead of decrementing
    set_ch(0, 2, 1);
    sync_tick();
    step_to(1);  phase_rst[0] = 1'b1;
    step_to(2);  phase_rst[0] = 1'b0;
    step_to(16); phase_rst[0] = 1'b1;
    step_to(17); phase_rst[0] = 1'b0;
    step_to(40); chk("prst_tick_hold", dut_ch(0), 26027);
    step_to(49); chk("prst_tick_last", dut_ch(0), 26027);
    step_to(50); chk("prst_tick_flip", dut_ch(0), -26027);

    // four full-scale voices: saturation both ways, then cancellation
    for (int k = 0; k < NCH; k++) set_ch(k, 1, 0);
    sync_tick();
    step_to(1);  phase_rst = '1;
    step_to(2);  phase_rst = '0;
    step_to(10); chk("mix_sat_pos", dut_mix(), 32767);
    step_to(18); chk("mix_sat_pos_last", dut_mix(), 32767);
    step_to(19); chk("mix_sat_neg", dut_mix(), -32767);
    step_to(20); chk("mix_sat_neg2", dut_mix(), -32767);
                 phase_rst = 4'b0011;
    step_to(21); phase_rst = '0;
    step_to(28); chk("mix_cancel", dut_mix(), 0);
                 chk("cancel_ch0", dut_ch(0), 32767);
                 chk("cancel_ch3", dut_ch(3), -32767);
    step_to(40); chk("mix_cancel_flip", dut_mix(), 0);

    // asynchronous reset mid-run
    sync_tick();
    step_to(3);
    #2 reset = 1'b0;
    #1;
    chk("areset_ch0", dut_ch(0), 0);
    chk("areset_ch3", dut_ch(3), 0);
    chk("areset_mix", dut_mix(), 0);
    step_to(5);  reset = 1'b1;
    step_to(10); chk("post_rst_p0", dut_ch(0), -32767);
    step_to(20); chk("post_rst_tick1", dut_ch(0), 32767);
    step_to(40); chk("post_rst_tick2", dut_ch(0), -32767);

    // maximum period: 1023 ticks per half, no early wrap
    for (int k = 1; k < NCH; k++) set_ch(k, 1, 15);
    set_ch(0, 1023, 1);
    sync_tick();
    step_to(1);     phase_rst[0] = 1'b1;
    step_to(2);     phase_rst[0] = 1'b0;
    step_to(16369); chk("nmax_pos_last", dut_ch(0), 26027);
    step_to(16370); chk("nmax_neg_first", dut_ch(0), -26027);
    step_to(32737); chk("nmax_neg_last", dut_ch(0), -26027);
    step_to(32738); chk("nmax_pos_again", dut_ch(0), 26027);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      phase_rst = ($urandom_range(0, 39) == 0) ? NCH'($urandom) : '0;
      if ($urandom_range(0, 47) == 0) begin
        ch_n[$urandom_range(0, NCH - 1) * NW +: NW] = NW'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 47) == 0) begin
        ch_att[$urandom_range(0, NCH - 1) * 4 +: 4] = 4'($urandom_range(0, 15));
      end
    end
    phase_rst = '0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
